// File: rtl/seg7_pkg.sv
// Shared types and defaults for the multiplexed seven-segment scan controller.
// Latency: none (declarations only). Backpressure: n/a.
// Holds the scan FSM state encoding, the blank segment pattern and parameter defaults.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam int DEF_DIGITS = 4;
    localparam int DEF_DWELL  = 4;
    localparam int DEF_GAP    = 1;

endpackage

// File: rtl/seg7_scan_ctrl_dec.sv
// Seven-segment decoder: 3-bit digit code to active-low {g,f,e,d,c,b,a} pattern.
// Latency: combinational. Backpressure: none.
// Single instance, shared by every digit position through the scan mux.
module seg7_scan_ctrl_dec (
    input  logic [2:0] code,
    output logic [6:0] seg
);

    always_comb begin
        unique case (code)
            3'd0: seg = 7'b1000000;
            3'd1: seg = 7'b1111001;
            3'd2: seg = 7'b0100100;
            3'd3: seg = 7'b0110000;
            3'd4: seg = 7'b0011001;
            3'd5: seg = 7'b0010010;
            3'd6: seg = 7'b0000010;
            3'd7: seg = 7'b1111000;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with shadowed digit-set writes.
// Latency: a write shows from the cycle after commit; commit waits for a frame boundary (or is immediate from IDLE).
// Backpressure: wr_ready = !pending; a second write stalls until the pending set commits.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS,
    parameter int DWELL  = DEF_DWELL,
    parameter int GAP    = DEF_GAP
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [3*DIGITS-1:0]   wr_data,
    input  logic [DIGITS-1:0]     wr_mask,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame_done
);

    localparam int CMAX = (DWELL > GAP) ? DWELL : GAP;
    localparam int CW   = $clog2(CMAX);
    localparam int KW   = $clog2(DIGITS);

    state_t              state, nxt_state;
    logic [KW-1:0]       k, nxt_k;
    logic [CW-1:0]       cnt, nxt_cnt;
    logic                pending;
    logic [3*DIGITS-1:0] shadow_data, act_data, sel_data;
    logic [DIGITS-1:0]   shadow_mask, act_mask, sel_mask;
    logic                frame_end, commit, accept, lit;
    logic [2:0]          code;
    logic [6:0]          dec_seg;

    assign wr_ready   = !pending;
    assign accept     = wr_valid && !pending;
    assign frame_end  = (state == BLANK) && (cnt == '0) && (k == KW'(DIGITS - 1));
    assign commit     = pending && ((state == IDLE) || frame_end);
    assign frame_done = frame_end;

    always_comb begin
        nxt_state = state;
        nxt_k     = k;
        nxt_cnt   = cnt;
        unique case (state)
            IDLE: begin
                if (pending) begin
                    nxt_state = SHOW;
                    nxt_k     = '0;
                    nxt_cnt   = CW'(DWELL - 1);
                end
            end
            SHOW: begin
                if (cnt == '0) begin
                    nxt_state = BLANK;
                    nxt_cnt   = CW'(GAP - 1);
                end else begin
                    nxt_cnt = cnt - 1'b1;
                end
            end
            BLANK: begin
                if (cnt == '0) begin
                    nxt_state = SHOW;
                    nxt_k     = (k == KW'(DIGITS - 1)) ? '0 : k + 1'b1;
                    nxt_cnt   = CW'(DWELL - 1);
                end else begin
                    nxt_cnt = cnt - 1'b1;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_k     = '0;
                nxt_cnt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state view, so on a commit edge the
    // freshly committed shadow set is what drives the first slot of the new frame.
    assign sel_data = commit ? shadow_data : act_data;
    assign sel_mask = commit ? shadow_mask : act_mask;
    assign code     = sel_data[3*int'(nxt_k) +: 3];
    assign lit      = (nxt_state == SHOW) && sel_mask[nxt_k];

    seg7_scan_ctrl_dec u_dec (
        .code (code),
        .seg  (dec_seg)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            k           <= '0;
            cnt         <= '0;
            pending     <= 1'b0;
            shadow_data <= '0;
            shadow_mask <= '0;
            act_data    <= '0;
            act_mask    <= '0;
            seg         <= SEG_OFF;
            dig_en      <= '0;
        end else begin
            state <= nxt_state;
            k     <= nxt_k;
            cnt   <= nxt_cnt;
            if (commit) begin
                act_data <= shadow_data;
                act_mask <= shadow_mask;
                pending  <= 1'b0;
            end
            if (accept) begin
                shadow_data <= wr_data;
                shadow_mask <= wr_mask;
                pending     <= 1'b1;
            end
            seg    <= lit ? dec_seg : SEG_OFF;
            dig_en <= lit ? (DIGITS'(1) << nxt_k) : '0;
        end
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 4: number of time-shared digit positions (2..8).
REQ-002 Parameter DWELL, default 4: cycles each digit is driven (>=2).
REQ-003 Parameter GAP, default 1: blanking cycles between digits (>=1).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 wr_valid  input  1  requester offers a new digit set.
REQ-007 wr_ready  output  1  controller can accept a digit set.
REQ-008 wr_data  input  3*DIGITS  digit codes; digit k in bits [3k+2:3k].
REQ-009 wr_mask  input  DIGITS  per-digit lit enable; 1 = lit, 0 = blanked.
REQ-010 seg  output  7  shared segment bus, active-low, seg7 code of the current digit.
REQ-011 dig_en  output  DIGITS  one-hot active-high digit select; all-zero when nothing is driven.
REQ-012 frame_done  output  1  single-cycle pulse at the end of each full scan.

Function
REQ-013 The FSM SHALL have states IDLE, SHOW, BLANK, plus a digit index k (0..DIGITS-1).
REQ-014 IDLE: seg=7'b1111111, dig_en=0; exit to SHOW with k=0 on the cycle after the first write commits.
REQ-015 SHOW SHALL last exactly DWELL cycles; then BLANK.
REQ-016 BLANK SHALL last exactly GAP cycles with dig_en=0 and seg=7'b1111111; then SHOW with k+1, wrapping DIGITS-1 -> 0.
REQ-017 A frame SHALL be DIGITS*(DWELL+GAP) cycles; frame_done pulses on the last BLANK cycle of k=DIGITS-1.
REQ-018 In SHOW, if the active mask bit k=1: dig_en has only bit k set, and seg = seg7 decode of active digit k.
REQ-019 In SHOW, if the active mask bit k=0: dig_en=0 and seg=7'b1111111; slot timing is unchanged.
REQ-020 seg and dig_en SHALL be registered outputs, with no combinational path from inputs.
REQ-021 A write is accepted when wr_valid && wr_ready; wr_data/wr_mask are captured into a shadow register, and pending is set.
REQ-022 wr_ready SHALL equal !pending.
REQ-023 Commit (shadow -> active, pending cleared) SHALL occur only at a frame boundary (the frame_done cycle), or on the first cycle of IDLE-pending; a displayed frame never mixes old and new data.
REQ-024 wr_ready SHALL rise on the cycle after commit; a wr_valid held through a low wr_ready is accepted that cycle.
REQ-025 The active digit set SHALL persist and repeat every frame until a new commit.
REQ-026 Dwell/gap counters SHALL be $clog2-sized and reload on every state entry, with no overflow.

Reset
REQ-027 While reset_n=0, immediately (asynchronously): state=IDLE, k=0, seg=7'b1111111, dig_en=0, frame_done=0, wr_ready=1, pending=0, active/shadow data=0, active mask=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame and any pending write; display stays off until a new write commits.

Structure
REQ-029 The shared package seg7_pkg SHALL hold: the state enum (IDLE/SHOW/BLANK), SEG_OFF=7'b1111111, and the default DIGITS/DWELL/GAP values.
REQ-030 Exactly one seg7 decoder instance (3-bit code -> 7-bit active-low pattern) SHALL be shared across all digits via the mux on k.

Verification (DIGITS=4, DWELL=4, GAP=1)
REQ-031 Reset release, then write data {3,2,1,0} with mask 4'b1111. Required response: dig_en=0001/seg=1000000 for 4 cycles, 1 blank cycle, then dig_en=0010/seg=1111001 for 4 cycles, through digit3 seg=0110000.
REQ-032 Mask 4'b0101. Required response: slots 1 and 3 show dig_en=0000 and seg=1111111 for 4 cycles each; frame_done period stays 20 cycles.
REQ-033 Second write {7,7,7,7} at cycle 6 of a frame. Required response: wr_ready=0 until the frame_done cycle; the remainder of the frame shows the old values; the next digit0 shows seg=1111000.
REQ-034 wr_valid held high while pending. Required response: exactly one extra accept, on the cycle after commit; no double capture.
REQ-035 reset_n pulsed low during SHOW of digit2. Required response: dig_en=0 and seg=1111111 in the same cycle; IDLE persists after release until a new write.
REQ-036 Free-running check over 5 frames. Required response: frame_done pulses exactly every 20 cycles, and dig_en is never multi-hot.
